// File: rtl/wind_ctrl.sv
// ---------------------------------------------------------------------------
// wind_ctrl -- wind source for the game.
//
// On each accepted new-turn request, draws a 7-bit pseudo-random target from a
// free-running 16-bit Galois LFSR and moves wind_force toward it. wind_force
// only changes on vertical-blank rising edges, so the indicator never tears.
//
// Optional feature macro: WIND_SLEW_EN
//   defined   : wind_force walks +/-1 every SLEW_FRAMES vblank edges.
//   undefined : wind_force jumps to the target on the first vblank edge.
//
// Parameters:
//   SLEW_FRAMES  vblank edges per +/-1 step (1..255)
//   LFSR_SEED    LFSR reset value (nonzero)
//   WIND_INIT    wind_force value after reset
//
// Ports:
//   clk         system (pixel) clock
//   rst         synchronous active-high reset
//   vblnk       vertical blank from the VGA timing chain
//   new_turn    single-cycle request for a new wind value
//   wind_force  current wind 0..127, registered
//   wind_busy   high while a request is in progress (requests dropped)
//   wind_done   one-cycle pulse when wind_force reaches the target
// ---------------------------------------------------------------------------
module wind_ctrl #(
    parameter int unsigned SLEW_FRAMES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [6:0]  WIND_INIT   = 7'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       new_turn,
    output logic [6:0] wind_force,
    output logic       wind_busy,
    output logic       wind_done
);

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        SLEW
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic        vblnk_q;
    logic [6:0]  target;
    logic        tick;

    if (SLEW_FRAMES < 1 || SLEW_FRAMES > 255) begin : g_bad_slew
        $error("wind_ctrl: SLEW_FRAMES must be in 1..255");
    end

    assign tick = vblnk & ~vblnk_q;

    // LFSR runs every cycle outside reset so the player's request timing
    // decides which value is drawn.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr    <= LFSR_SEED;
            vblnk_q <= 1'b0;
        end else begin
            lfsr    <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            vblnk_q <= vblnk;
        end
    end

`ifdef WIND_SLEW_EN
    localparam logic [7:0] FRAME_LAST = 8'(SLEW_FRAMES - 1);

    logic [7:0] frame_cnt;
    logic [6:0] wind_next;

    // One unit toward the target; never wraps since target is in range.
    assign wind_next = (target > wind_force) ? wind_force + 7'd1
                                             : wind_force - 7'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wind_force <= WIND_INIT;
            wind_busy  <= 1'b0;
            wind_done  <= 1'b0;
            target     <= WIND_INIT;
`ifdef WIND_SLEW_EN
            frame_cnt  <= '0;
`endif
        end else begin
            wind_done <= 1'b0;
            case (state)
                IDLE: begin
                    // A coincident tick is irrelevant here; only the request matters.
                    if (new_turn) begin
                        state     <= PICK;
                        wind_busy <= 1'b1;
                    end
                end
                PICK: begin
                    target <= lfsr[6:0];
`ifdef WIND_SLEW_EN
                    frame_cnt <= '0;
`endif
                    if (lfsr[6:0] == wind_force) begin
                        state     <= IDLE;
                        wind_busy <= 1'b0;
                        wind_done <= 1'b1;
                    end else begin
                        state <= SLEW;
                    end
                end
                SLEW: begin
                    if (tick) begin
`ifdef WIND_SLEW_EN
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt  <= '0;
                            wind_force <= wind_next;
                            if (wind_next == target) begin
                                state     <= IDLE;
                                wind_busy <= 1'b0;
                                wind_done <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
`else
                        wind_force <= target;
                        state      <= IDLE;
                        wind_busy  <= 1'b0;
                        wind_done  <= 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    wind_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wind_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wind_ctrl -- self-checking bench for wind_ctrl.
// Follows WIND_SLEW_EN the same way as the design (slew vs. jump behaviour).
// vblnk is a bench-generated frame: 8 cycles per frame, high for 2.
// ---------------------------------------------------------------------------
module tb_wind_ctrl;

    localparam int          SF     = 2;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          BUDGET = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vblnk = 1'b0;
    logic       new_turn = 1'b0;
    logic [6:0] wind_force;
    logic       wind_busy;
    logic       wind_done;

    wind_ctrl #(
        .SLEW_FRAMES(SF),
        .LFSR_SEED  (SEED),
        .WIND_INIT  (7'd64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vblnk),
        .new_turn  (new_turn),
        .wind_force(wind_force),
        .wind_busy (wind_busy),
        .wind_done (wind_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned delay;      // idle cycles before the request
        logic        align;      // request coincides with a vblank edge
        int unsigned drops;      // extra new_turn pulses while busy
        int unsigned exp_dones;  // wind_done pulses expected for the turn
    } turn_vec_t;

    typedef struct {
        int tgt;
        int ticks;
    } sb_t;

    sb_t         sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          exp_wind = 64;

    // Reference LFSR / tick model, updated at each active edge.
    logic [15:0] m_lfsr = SEED;
    logic        m_vq = 1'b0;
    logic        m_tick = 1'b0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        m_tick = vblnk & ~m_vq;
        if (rst) begin
            m_vq   = 1'b0;
            m_lfsr = SEED;
        end else begin
            m_vq   = vblnk;
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs for the next edge, then return at the following negedge.
    task automatic clk_cycle(input logic nt);
        new_turn = nt;
        vblnk    = ((cyc % 8) < 2);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        clk_cycle(1'b0);
        chk("idle_wind", wind_force, exp_wind);
        chk("idle_busy", wind_busy, 0);
        chk("idle_done", wind_done, 0);
    endtask

    // Idle until the draw taken at the next request satisfies the predicate:
    // eq=1 -> equals current wind, eq=0 -> at least 4 away.
    task automatic wait_target(input bit eq);
        logic [15:0] nxt;
        int          d;
        bit          found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            nxt = lfsr_step(m_lfsr);
            d   = int'(nxt[6:0]) - exp_wind;
            if (eq ? (d == 0) : (d >= 4 || d <= -4)) found = 1'b1;
            else idle_cycle();
        end
        chk("wait_target", found, 1);
    endtask

    task automatic observe(input bit fin, input int ticks, inout int dones);
        sb_t e;
        chk("wind_force", wind_force, exp_wind);
        chk("wind_busy", wind_busy, !fin);
        chk("wind_done", wind_done, fin);
        if (wind_done === 1'b1) begin
            dones++;
            chk("sb_pending", int'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_target", wind_force, e.tgt);
                chk("sb_ticks", ticks, e.ticks);
            end
        end
    endtask

    task automatic run_turn(input turn_vec_t v, input bit want_equal);
        int  tgt, ticks, cnt, k, dones, drops_left, d;
        bit  fin;
        logic nt;
        sb_t e;
        if (want_equal) begin
            wait_target(1'b1);
        end else begin
            for (int i = 0; i < int'(v.delay); i++) idle_cycle();
            if (v.align) for (int i = 0; i < 8 && (cyc % 8) != 0; i++) idle_cycle();
        end
        clk_cycle(1'b1);                      // edge N
        tgt = int'(m_lfsr[6:0]);              // LFSR as held during cycle N+1
        d   = (tgt > exp_wind) ? tgt - exp_wind : exp_wind - tgt;
        e.tgt = tgt;
`ifdef WIND_SLEW_EN
        e.ticks = d * SF;
`else
        e.ticks = (d == 0) ? 0 : 1;
`endif
        sbq.push_back(e);
        chk("accept_busy", wind_busy, 1);
        chk("accept_done", wind_done, 0);
        chk("accept_wind", wind_force, exp_wind);
        clk_cycle(1'b0);                      // edge N+1: PICK
        fin = (tgt == exp_wind);
        ticks = 0; cnt = 0; dones = 0; drops_left = int'(v.drops); k = 0;
        observe(fin, ticks, dones);
        while (!fin && k < BUDGET) begin
            nt = (drops_left > 0 && (k % 3) == 1);
            if (nt) drops_left--;
            clk_cycle(nt);
            k++;
            if (m_tick) begin
                ticks++;
`ifdef WIND_SLEW_EN
                if (cnt == SF - 1) begin
                    cnt = 0;
                    exp_wind += (tgt > exp_wind) ? 1 : -1;
                    if (exp_wind == tgt) fin = 1'b1;
                end else begin
                    cnt++;
                end
`else
                exp_wind = tgt;
                fin      = 1'b1;
`endif
            end
            observe(fin, ticks, dones);
        end
        idle_cycle();
        chk("done_count", dones, v.exp_dones);
    endtask

    turn_vec_t vecs[5];

    initial begin
        int tgt, cnt, steps;
        vecs[0] = '{delay: 3,  align: 1'b0, drops: 0, exp_dones: 1};
        vecs[1] = '{delay: 5,  align: 1'b1, drops: 0, exp_dones: 1};
        vecs[2] = '{delay: 0,  align: 1'b0, drops: 3, exp_dones: 1};
        vecs[3] = '{delay: 17, align: 1'b0, drops: 0, exp_dones: 1};
        vecs[4] = '{delay: 1,  align: 1'b1, drops: 3, exp_dones: 1};

        // Reset held for 3 cycles.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) clk_cycle(1'b0);
        chk("rst_wind", wind_force, 64);
        chk("rst_busy", wind_busy, 0);
        chk("rst_done", wind_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) idle_cycle();   // five vblank edges, no request

        foreach (vecs[i]) run_turn(vecs[i], 1'b0);

        // Reset in the middle of a slew.
        wait_target(1'b0);
        clk_cycle(1'b1);
        tgt = int'(m_lfsr[6:0]);
        chk("mid_accept_busy", wind_busy, 1);
        clk_cycle(1'b0);
        chk("mid_pick_busy", wind_busy, 1);
        chk("mid_pick_done", wind_done, 0);
`ifdef WIND_SLEW_EN
        cnt = 0; steps = 0;
        for (int k = 0; k < BUDGET && steps < 3; k++) begin
            clk_cycle(1'b0);
            if (m_tick) begin
                if (cnt == SF - 1) begin
                    cnt = 0;
                    exp_wind += (tgt > exp_wind) ? 1 : -1;
                    steps++;
                end else begin
                    cnt++;
                end
            end
            chk("mid_wind", wind_force, exp_wind);
            chk("mid_busy", wind_busy, 1);
            chk("mid_done", wind_done, 0);
        end
`else
        steps = 0;
        cnt   = tgt;
`endif
        rst = 1'b1;
        clk_cycle(1'b0);
        chk("mid_rst_wind", wind_force, 64);
        chk("mid_rst_busy", wind_busy, 0);
        chk("mid_rst_done", wind_done, 0);
        rst = 1'b0;
        exp_wind = 64;
        for (int i = 0; i < 10; i++) idle_cycle();

        // Draw equal to the current wind: done right after PICK, no movement.
        run_turn('{delay: 0, align: 1'b0, drops: 0, exp_dones: 1}, 1'b1);

        // A final ordinary turn from the post-reset state.
        run_turn(vecs[0], 1'b0);

        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
